axis_packet_merger: RTL and testbench

- Single-channel AXI-Stream stage directly downstream of the packet splitter.
- Consumes a run of `pckt_count` sub-packets, each exactly `pckt_size` beats and terminated by `tlast`.
- Re-emits them as one contiguous output packet with a single `tlast` on the final beat.
- Checks sub-packet framing and reports busy/complete/error status with the same flag semantics as the splitter, so both stages can share one control/interrupt scheme.

---
 rtl/axis_packet_merger_pkg.sv | 20 ++
 rtl/axis_packet_merger.sv | 141 ++++++++++++++
 tb/tb_axis_packet_merger.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_packet_merger_pkg.sv
// -----------------------------------------------------------------------------
// axis_packet_merger_pkg
//   Shared control definitions for the splitter/merger AXI-Stream stages.
//   Holds the state encoding, so both stages report status through the same
//   IDLE/RUN/DONE/ERROR scheme, and a small helper used by the FSMs.
//   No ports (package).
// -----------------------------------------------------------------------------
package axis_packet_merger_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_ERROR = 2'd3;

    // A new operation may only be armed while no transfer is in flight.
    function automatic logic can_start(input logic [1:0] st);
        return (st != ST_RUN);
    endfunction

endpackage

// File: rtl/axis_packet_merger.sv
// -----------------------------------------------------------------------------
// axis_packet_merger
//   Merges a run of pckt_count sub-packets (pckt_size beats each, framed by
//   tlast from the upstream splitter) into one output packet with a single
//   tlast on its final beat. Zero-latency pass-through while running; framing
//   is checked against the configured size and status is reported with the
//   same busy/complete/error flags as the splitter.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   operation_start        latch pckt_size/pckt_count and arm (not in RUN)
//   pckt_size, pckt_count  beats per sub-packet, sub-packets per merge
//   external_error         abort request while running
//   operation_busy/complete/error  registered status (RUN/DONE/ERROR)
//   transmission           input handshake this cycle
//   s_axis_*               sub-packet input stream
//   m_axis_*               merged output stream
// -----------------------------------------------------------------------------
module axis_packet_merger
    import axis_packet_merger_pkg::*;
#(
    parameter int DATA_WIDTH          = 16,
    parameter int KEEP_ENABLE         = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH          = KEEP_ENABLE ? (DATA_WIDTH + 7) / 8 : 1,
    parameter int ID_ENABLE           = 0,
    parameter int ID_WIDTH            = ID_ENABLE ? 8 : 1,
    parameter int DEST_ENABLE         = 0,
    parameter int DEST_WIDTH          = DEST_ENABLE ? 8 : 1,
    parameter int USER_ENABLE         = 0,
    parameter int USER_WIDTH          = USER_ENABLE ? 8 : 1,
    parameter int PCKT_WIDTH          = 32,
    parameter int CNT_WIDTH           = 16,
    parameter int RAISE_SIZE_MISMATCH = 1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  operation_start,
    input  logic [PCKT_WIDTH-1:0] pckt_size,
    input  logic [CNT_WIDTH-1:0]  pckt_count,
    input  logic                  external_error,
    output logic                  operation_busy,
    output logic                  operation_complete,
    output logic                  operation_error,
    output logic                  transmission,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [ID_WIDTH-1:0]   s_axis_tid,
    input  logic [DEST_WIDTH-1:0] s_axis_tdest,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [ID_WIDTH-1:0]   m_axis_tid,
    output logic [DEST_WIDTH-1:0] m_axis_tdest,
    output logic [USER_WIDTH-1:0] m_axis_tuser
);

    logic [1:0]            r_state;
    logic [PCKT_WIDTH-1:0] r_size;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [PCKT_WIDTH-1:0] r_beat_cnt;
    logic [CNT_WIDTH-1:0]  r_pkt_cnt;

    logic w_run;
    logic w_hs;
    logic w_last_beat;
    logic w_last_pkt;
    logic w_mismatch;
    logic w_cfg_bad;

    assign w_run       = (r_state == ST_RUN);
    assign w_hs        = s_axis_tvalid & s_axis_tready;
    // Counters are compared against the latched config only; the config is
    // never zero while running, so the "-1" cannot underflow in RUN.
    assign w_last_beat = (r_beat_cnt == r_size - PCKT_WIDTH'(1));
    assign w_last_pkt  = (r_pkt_cnt == r_count - CNT_WIDTH'(1));
    assign w_mismatch  = (RAISE_SIZE_MISMATCH != 0) && (s_axis_tlast != w_last_beat);
    assign w_cfg_bad   = (pckt_size == '0) || (pckt_count == '0);

    // Combinational pass-through; handshake gated by state only.
    assign s_axis_tready = w_run & m_axis_tready;
    assign m_axis_tvalid = w_run & s_axis_tvalid;
    // Input tlast is never forwarded; a framing error closes the downstream
    // packet early so the sink never sees an unterminated packet.
    assign m_axis_tlast  = w_run & ((w_last_beat & w_last_pkt) | w_mismatch);
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tkeep  = (KEEP_ENABLE != 0) ? s_axis_tkeep : '0;
    assign m_axis_tid    = (ID_ENABLE   != 0) ? s_axis_tid   : '0;
    assign m_axis_tdest  = (DEST_ENABLE != 0) ? s_axis_tdest : '0;
    assign m_axis_tuser  = (USER_ENABLE != 0) ? s_axis_tuser : '0;

    assign transmission       = w_hs;
    assign operation_busy     = w_run;
    assign operation_complete = (r_state == ST_DONE);
    assign operation_error    = (r_state == ST_ERROR);

    // Configuration latch: only meaningful once armed, so no reset needed.
    always_ff @(posedge clk) begin
        if (can_start(r_state) && operation_start) begin
            r_size  <= pckt_size;
            r_count <= pckt_count;
        end
    end

    // Control FSM and beat/packet counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_beat_cnt <= '0;
            r_pkt_cnt  <= '0;
        end else if (w_run) begin
            if (w_hs) begin
                if (w_last_beat) begin
                    r_beat_cnt <= '0;
                    r_pkt_cnt  <= r_pkt_cnt + CNT_WIDTH'(1);
                end else begin
                    r_beat_cnt <= r_beat_cnt + PCKT_WIDTH'(1);
                end
            end
            // Error takes priority over a coinciding completion.
            if (external_error || (w_hs && w_mismatch)) begin
                r_state <= ST_ERROR;
            end else if (w_hs && w_last_beat && w_last_pkt) begin
                r_state <= ST_DONE;
            end
        end else if (operation_start) begin
            r_beat_cnt <= '0;
            r_pkt_cnt  <= '0;
            r_state    <= w_cfg_bad ? ST_ERROR : ST_RUN;
        end
    end

endmodule

// File: tb/tb_axis_packet_merger.sv
// -----------------------------------------------------------------------------
// tb_axis_packet_merger
//   Two merger instances (framing check on / off) share one stimulus. A
//   behavioural model per instance tracks the merged-packet position as a
//   single beat index and derives every output from it; a negedge monitor
//   compares both DUTs against it each cycle. Directed scenarios add literal
//   expectations, then a randomized phase runs.
// -----------------------------------------------------------------------------
module tb_axis_packet_merger;

    localparam int DW = 16;
    localparam int KW = 2;
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_ERR = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start  = 1'b0;
    logic [31:0]   psize  = '0;
    logic [15:0]   pcount = '0;
    logic          ext    = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic [KW-1:0] s_keep = '0;
    logic          s_valid = 1'b0;
    logic          s_last  = 1'b0;
    logic          m_ready = 1'b0;
    logic          s_side  = 1'b1;

    logic [1:0] busy, comp, err, trans, s_ready, m_valid, m_last, m_id, m_dest, m_user;
    logic [1:0][DW-1:0] m_data;
    logic [1:0][KW-1:0] m_keep;

    axis_packet_merger #(.RAISE_SIZE_MISMATCH(1)) u_dut (
        .clk(clk), .rst(rst),
        .operation_start(start), .pckt_size(psize), .pckt_count(pcount),
        .external_error(ext),
        .operation_busy(busy[0]), .operation_complete(comp[0]),
        .operation_error(err[0]), .transmission(trans[0]),
        .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tvalid(s_valid),
        .s_axis_tready(s_ready[0]), .s_axis_tlast(s_last), .s_axis_tid(s_side),
        .s_axis_tdest(s_side), .s_axis_tuser(s_side),
        .m_axis_tdata(m_data[0]), .m_axis_tkeep(m_keep[0]), .m_axis_tvalid(m_valid[0]),
        .m_axis_tready(m_ready), .m_axis_tlast(m_last[0]), .m_axis_tid(m_id[0]),
        .m_axis_tdest(m_dest[0]), .m_axis_tuser(m_user[0])
    );

    axis_packet_merger #(.RAISE_SIZE_MISMATCH(0)) u_dut_nm (
        .clk(clk), .rst(rst),
        .operation_start(start), .pckt_size(psize), .pckt_count(pcount),
        .external_error(ext),
        .operation_busy(busy[1]), .operation_complete(comp[1]),
        .operation_error(err[1]), .transmission(trans[1]),
        .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tvalid(s_valid),
        .s_axis_tready(s_ready[1]), .s_axis_tlast(s_last), .s_axis_tid(s_side),
        .s_axis_tdest(s_side), .s_axis_tuser(s_side),
        .m_axis_tdata(m_data[1]), .m_axis_tkeep(m_keep[1]), .m_axis_tvalid(m_valid[1]),
        .m_axis_tready(m_ready), .m_axis_tlast(m_last[1]), .m_axis_tid(m_id[1]),
        .m_axis_tdest(m_dest[1]), .m_axis_tuser(m_user[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic string nmi(input string s, input int i);
        return $sformatf("%s[%0d]", s, i);
    endfunction

    // Behavioural model: mode, latched config and index of the next beat
    // inside the merged packet (0 .. size*count-1).
    int     md[2]  = '{M_IDLE, M_IDLE};
    longint sz[2]  = '{1, 1};
    longint cn[2]  = '{1, 1};
    longint kk[2]  = '{0, 0};

    // Observed statistics for the literal checks of directed scenarios.
    int txc[2], tlast_pos[2], tlast_cnt[2], busyc[2];
    logic mon = 1'b0;

    always @(negedge clk) begin
        if (mon) begin
            for (int i = 0; i < 2; i++) begin
                bit run, exp_rdy, lb, fin, mm, hs;
                run     = (md[i] == M_RUN);
                exp_rdy = run & m_ready;
                chk(nmi("busy", i),     64'(busy[i]),    64'(run));
                chk(nmi("complete", i), 64'(comp[i]),    64'(md[i] == M_DONE));
                chk(nmi("error", i),    64'(err[i]),     64'(md[i] == M_ERR));
                chk(nmi("s_tready", i), 64'(s_ready[i]), 64'(exp_rdy));
                chk(nmi("m_tvalid", i), 64'(m_valid[i]), 64'(run & s_valid));
                chk(nmi("transm", i),   64'(trans[i]),   64'(s_valid & exp_rdy));
                chk(nmi("m_tid", i),    64'(m_id[i]),    64'(0));
                chk(nmi("m_tdest", i),  64'(m_dest[i]),  64'(0));
                chk(nmi("m_tuser", i),  64'(m_user[i]),  64'(0));
                lb = 1'b0; fin = 1'b0; mm = 1'b0;
                if (run) begin
                    lb  = ((kk[i] % sz[i]) == sz[i] - 1);
                    fin = (kk[i] == sz[i] * cn[i] - 1);
                    mm  = (i == 0) && (s_last != lb);
                    if (s_valid) begin
                        chk(nmi("m_tlast", i), 64'(m_last[i]), 64'(fin | mm));
                        chk(nmi("m_tdata", i), 64'(m_data[i]), 64'(s_data));
                        chk(nmi("m_tkeep", i), 64'(m_keep[i]), 64'(s_keep));
                    end
                end else begin
                    chk(nmi("m_tlast_idle", i), 64'(m_last[i]), 64'(0));
                end
                hs = s_valid & exp_rdy;

                if (trans[i]) begin
                    txc[i]++;
                    if (m_last[i]) begin
                        tlast_cnt[i]++;
                        tlast_pos[i] = txc[i] - 1;
                    end
                end
                if (busy[i]) busyc[i]++;

                if (rst) begin
                    md[i] = M_IDLE;
                    kk[i] = 0;
                end else if (run) begin
                    if (hs) kk[i]++;
                    if (ext || (hs && mm)) md[i] = M_ERR;
                    else if (hs && fin)    md[i] = M_DONE;
                end else if (start) begin
                    sz[i] = longint'(psize);
                    cn[i] = longint'(pcount);
                    kk[i] = 0;
                    md[i] = (psize == 0 || pcount == 0) ? M_ERR : M_RUN;
                end
            end
        end
    end

    logic bp = 1'b0;
    always @(posedge clk) begin
        if (bp) begin
            #1 m_ready = ~m_ready;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_stats();
        for (int i = 0; i < 2; i++) begin
            txc[i] = 0; tlast_pos[i] = -1; tlast_cnt[i] = 0; busyc[i] = 0;
        end
    endtask

    task automatic do_start(input int unsigned s, input int unsigned c);
        psize  = 32'(s);
        pcount = 16'(c);
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // Offer one beat and hold it until instance f accepts it.
    task automatic send_beat(input int f, input logic last);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = DW'($urandom);
        s_keep  = KW'($urandom);
        s_last  = last;
        @(negedge clk);
        while (!s_ready[f]) begin
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL beat_timeout inst=%0d actual=no_ready expected=ready", f);
                s_valid = 1'b0;
                s_last  = 1'b0;
                return;
            end
            @(negedge clk);
        end
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    initial begin
        clr_stats();
        @(posedge clk);
        mon = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_busy",   64'(busy[0]),    0);
        chk("reset_err",    64'(err[0]),     0);
        chk("reset_tready", 64'(s_ready[0]), 0);

        // Nominal: 4x3, always-ready sink.
        m_ready = 1'b1;
        clr_stats();
        do_start(4, 3);
        for (int b = 0; b < 12; b++) send_beat(0, (b % 4) == 3);
        chk("nom_complete",  64'(comp[0]),      1);
        chk("nom_tx",        64'(txc[0]),       12);
        chk("nom_tlast_pos", 64'(tlast_pos[0]), 11);
        chk("nom_tlast_cnt", 64'(tlast_cnt[0]), 1);
        chk("nom_busy_cyc",  64'(busyc[0]),     12);

        // Backpressure: sink ready toggles every cycle.
        clr_stats();
        bp = 1'b1;
        do_start(4, 3);
        for (int b = 0; b < 12; b++) send_beat(0, (b % 4) == 3);
        bp = 1'b0;
        tick();
        m_ready = 1'b1;
        chk("bp_complete",  64'(comp[0]),      1);
        chk("bp_tx",        64'(txc[0]),       12);
        chk("bp_tlast_pos", 64'(tlast_pos[0]), 11);

        // Early tlast on beat 2: checked instance errors, unchecked one completes.
        clr_stats();
        do_start(4, 2);
        for (int b = 0; b < 8; b++) begin
            send_beat(1, b == 2);
            if (b == 2) begin
                chk("early_err",    64'(err[0]),     1);
                chk("early_tready", 64'(s_ready[0]), 0);
            end
        end
        chk("early_tlast_pos", 64'(tlast_pos[0]), 2);
        chk("early_tx",        64'(txc[0]),       3);
        chk("nm_complete",     64'(comp[1]),      1);
        chk("nm_err",          64'(err[1]),       0);
        chk("nm_tlast_pos",    64'(tlast_pos[1]), 7);

        // Abort after 5 of 8 beats, then recover with 2x1.
        do_start(4, 2);
        for (int b = 0; b < 5; b++) send_beat(0, (b % 4) == 3);
        ext = 1'b1;
        tick();
        ext = 1'b0;
        chk("abort_err",    64'(err[0]),     1);
        chk("abort_tready", 64'(s_ready[0]), 0);
        clr_stats();
        do_start(2, 1);
        chk("recover_busy", 64'(busy[0]), 1);
        for (int b = 0; b < 2; b++) send_beat(0, b == 1);
        chk("recover_complete", 64'(comp[0]),      1);
        chk("recover_tlast",    64'(tlast_pos[0]), 1);

        // Zero configuration goes straight to ERROR.
        do_start(0, 3);
        chk("size0_err", 64'(err[0]), 1);
        do_start(3, 0);
        chk("count0_err", 64'(err[1]), 1);

        // Reset at beat 3.
        do_start(4, 3);
        for (int b = 0; b < 3; b++) send_beat(0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_busy",   64'(busy[0]),    0);
        chk("rst_comp",   64'(comp[0]),    0);
        chk("rst_err",    64'(err[0]),     0);
        chk("rst_tready", 64'(s_ready[0]), 0);

        // Start pulsed during RUN is ignored.
        clr_stats();
        do_start(4, 3);
        for (int b = 0; b < 2; b++) send_beat(0, 1'b0);
        do_start(2, 1);
        for (int b = 2; b < 12; b++) send_beat(0, (b % 4) == 3);
        chk("midstart_complete", 64'(comp[0]),      1);
        chk("midstart_tx",       64'(txc[0]),       12);
        chk("midstart_tlast",    64'(tlast_pos[0]), 11);

        // Randomized phase.
        for (int c = 0; c < 4000; c++) begin
            s_valid = ($urandom % 4) != 0;
            s_data  = DW'($urandom);
            s_keep  = KW'($urandom);
            s_last  = ($urandom % 4) == 0;
            m_ready = ($urandom % 4) != 0;
            ext     = ($urandom % 64) == 0;
            start   = ($urandom % 6) == 0;
            psize   = (($urandom % 16) == 0) ? 32'd0 : 32'($urandom_range(1, 4));
            pcount  = (($urandom % 16) == 0) ? 16'd0 : 16'($urandom_range(1, 3));
            rst     = ($urandom % 400) == 0;
            tick();
        end
        s_valid = 1'b0; start = 1'b0; ext = 1'b0; rst = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
